// File: rtl/aap_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aap_fetch_pkg : shared constants and types for the AAP fetch stage  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package aap_fetch_pkg;

  localparam int AAP_PC_W     = 24;
  localparam int AAP_LONG_BIT = 15;

  typedef logic [15:0] word_t;

  // Number of 16-bit words occupied by the instruction whose first word is w.
  function automatic logic [1:0] inst_words(input word_t w);
    return w[AAP_LONG_BIT] ? 2'd2 : 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aap_fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aap_fetch_if : memory read port and Execute handshake of aap_fetch  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface aap_fetch_if
  import aap_fetch_pkg::*;
#(
  parameter int PC_W = AAP_PC_W
);

  logic [PC_W-1:0] i_raddr;
  word_t           i_rdata;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic            inst_long;
  logic [PC_W-1:0] inst_pc;

  modport master (
    output i_raddr,
    input  i_rdata,
    input  redirect,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_long,
    output inst_pc
  );

  modport slave (
    input  i_raddr,
    output i_rdata,
    output redirect,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_long,
    input  inst_pc
  );

endinterface
`default_nettype wire

// File: rtl/aap_word_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aap_word_fifo : circular 16-bit word queue, push 1 / pop 0..2      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module aap_word_fifo
  import aap_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  word_t            push_data,
  input  logic [1:0]       pop_n,
  output word_t            head0,
  output word_t            head1,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  word_t            mem [DEPTH];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      count  <= count + CNT_W'(push) - CNT_W'(pop_n);
    end
  end

endmodule
`default_nettype wire

// File: rtl/aap_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aap_fetch : AAP instruction fetch, prefetch queue and 16/32 decode |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module aap_fetch
  import aap_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = AAP_PC_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  aap_fetch_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]  fpc;
  logic [PC_W-1:0]  head_pc;
  logic             req_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  word_t            w0;
  word_t            w1;
  logic             issue;
  logic             push;
  logic             long_inst;
  logic             take;
  logic [1:0]       pop_n;

  // The in-flight word counts as occupied so it always finds a free slot.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, req_q};
  assign issue     = fetch_en & ~bus.redirect & (occupancy < (CNT_W+1)'(DEPTH));
  assign push      = req_q & ~bus.redirect;

  assign long_inst      = w0[AAP_LONG_BIT];
  assign bus.inst_valid = long_inst ? (count >= CNT_W'(2)) : (count != '0);
  assign bus.inst       = long_inst ? {w1, w0} : {16'h0000, w0};
  assign bus.inst_long  = long_inst;
  assign bus.inst_pc    = head_pc;
  assign bus.i_raddr    = fpc;

  assign take  = bus.inst_valid & bus.inst_ready;
  assign pop_n = take ? inst_words(w0) : 2'd0;

  aap_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.redirect),
    .push      (push),
    .push_data (bus.i_rdata),
    .pop_n     (pop_n),
    .head0     (w0),
    .head1     (w1),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc     <= '0;
      req_q   <= 1'b0;
      head_pc <= '0;
    end else if (bus.redirect) begin
      fpc     <= bus.redirect_pc;
      req_q   <= 1'b0;
      head_pc <= bus.redirect_pc;
    end else begin
      req_q <= issue;
      if (issue) begin
        fpc <= fpc + PC_W'(1);
      end
      if (take) begin
        head_pc <= head_pc + PC_W'(pop_n);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aap_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_aap_fetch : directed + random bench with instruction-stream model|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_aap_fetch;

  localparam int DEPTH = 4;
  localparam int PC_W  = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fetch_en = 1'b0;

  int total   = 0;
  int bad     = 0;
  int retired = 0;

  logic [PC_W-1:0] exp_pc = '0;
  logic [15:0]     ovr [int unsigned];

  aap_fetch_if #(.PC_W(PC_W)) bus ();

  aap_fetch #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_en (fetch_en),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction memory: explicit overrides, otherwise a fixed hash of the address.
  function automatic logic [15:0] mem_word(input logic [PC_W-1:0] a);
    logic [31:0] h;
    if (ovr.exists(32'(a))) return ovr[32'(a)];
    h = 32'(a) * 32'h9E3779B1;
    return h[31:16] ^ h[15:0];
  endfunction

  function automatic logic [31:0] ref_inst(input logic [PC_W-1:0] pc);
    logic [15:0]     w0;
    logic [PC_W-1:0] nxt;
    w0  = mem_word(pc);
    nxt = pc + 24'd1;
    if (w0[15]) return {mem_word(nxt), w0};
    return {16'h0000, w0};
  endfunction

  always @(posedge clk) bus.i_rdata <= mem_word(bus.i_raddr);

  // Program-order scoreboard: every accepted instruction must be the next one.
  always @(negedge clk) begin : sb
    logic [15:0] w;
    w = mem_word(exp_pc);
    if (bus.inst_valid && bus.inst_ready) begin
      check_eq("sb_pc", 32'(bus.inst_pc), 32'(exp_pc));
      check_eq("sb_inst", bus.inst, ref_inst(exp_pc));
      check_eq("sb_long", 32'(bus.inst_long), 32'(w[15]));
      exp_pc  <= exp_pc + (w[15] ? 24'd2 : 24'd1);
      retired <= retired + 1;
    end
    if (rst) exp_pc <= '0;
    else if (bus.redirect) exp_pc <= bus.redirect_pc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_en = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int r0;
    bit found;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b0;
    step();

    // Short instructions stream back-to-back from cycle 2.
    ovr[0] = 16'h0001; ovr[1] = 16'h0002; ovr[2] = 16'h0003;
    do_reset();
    fetch_en = 1'b1; bus.inst_ready = 1'b1;
    look();
    check_eq("rst_valid", 32'(bus.inst_valid), 0);
    check_eq("rst_raddr", 32'(bus.i_raddr), 0);
    check_eq("rst_pc", 32'(bus.inst_pc), 0);
    step(); look();
    check_eq("t1_lat_valid", 32'(bus.inst_valid), 0);
    for (int k = 0; k < 3; k++) begin
      step(); look();
      check_eq("t1_valid", 32'(bus.inst_valid), 1);
      check_eq("t1_inst", bus.inst, 32'(k + 1));
      check_eq("t1_pc", 32'(bus.inst_pc), 32'(k));
    end

    // Long instruction assembled from two words.
    ovr[0] = 16'h8123; ovr[1] = 16'h4567; ovr[2] = 16'h0042;
    do_reset();
    fetch_en = 1'b1; bus.inst_ready = 1'b1;
    step(); look();
    check_eq("t2_e0_valid", 32'(bus.inst_valid), 0);
    step(); look();
    check_eq("t2_half_valid", 32'(bus.inst_valid), 0);
    step(); look();
    check_eq("t2_valid", 32'(bus.inst_valid), 1);
    check_eq("t2_inst", bus.inst, 32'h45678123);
    check_eq("t2_long", 32'(bus.inst_long), 1);
    check_eq("t2_pc", 32'(bus.inst_pc), 0);
    step(); look();
    check_eq("t2_next_pc", 32'(bus.inst_pc), 2);
    check_eq("t2_next_inst", bus.inst, 32'h00000042);

    // Backpressure: fetch stalls once the queue is full.
    do_reset();
    fetch_en = 1'b1;
    repeat (10) step();
    look();
    check_eq("t3_raddr_hold", 32'(bus.i_raddr), DEPTH);
    check_eq("t3_valid", 32'(bus.inst_valid), 1);
    step(); look();
    check_eq("t3_raddr_hold2", 32'(bus.i_raddr), DEPTH);
    step();
    bus.inst_ready = 1'b1;
    repeat (8) step();

    // Redirect with a full queue and a read in flight.
    ovr[32'h100] = 16'h0100;
    do_reset();
    fetch_en = 1'b1;
    repeat (4) step();
    bus.redirect = 1'b1; bus.redirect_pc = 24'h000100;
    step();
    bus.redirect = 1'b0;
    look();
    check_eq("t4_raddr", 32'(bus.i_raddr), 32'h100);
    check_eq("t4_valid0", 32'(bus.inst_valid), 0);
    step(); look();
    check_eq("t4_valid1", 32'(bus.inst_valid), 0);
    step(); look();
    check_eq("t4_valid2", 32'(bus.inst_valid), 1);
    check_eq("t4_pc", 32'(bus.inst_pc), 32'h100);
    check_eq("t4_inst", bus.inst, 32'h00000100);
    step();
    bus.inst_ready = 1'b1;
    repeat (6) step();

    // Long instruction straddling the address wrap.
    do_reset();
    ovr[32'hFFFFFF] = 16'h8AAA; ovr[0] = 16'h5555;
    fetch_en = 1'b1; bus.inst_ready = 1'b1;
    bus.redirect = 1'b1; bus.redirect_pc = 24'hFFFFFF;
    step();
    bus.redirect = 1'b0;
    look();
    check_eq("t5_raddr", 32'(bus.i_raddr), 32'hFFFFFF);
    check_eq("t5_valid0", 32'(bus.inst_valid), 0);
    step(); look();
    check_eq("t5_valid1", 32'(bus.inst_valid), 0);
    step(); look();
    check_eq("t5_valid2", 32'(bus.inst_valid), 0);
    step(); look();
    check_eq("t5_valid3", 32'(bus.inst_valid), 1);
    check_eq("t5_inst", bus.inst, 32'h55558AAA);
    check_eq("t5_pc", 32'(bus.inst_pc), 32'hFFFFFF);
    step(); look();
    check_eq("t5_next_pc", 32'(bus.inst_pc), 1);

    // Reset while a long instruction is only half queued.
    do_reset();
    ovr[0] = 16'h8123;
    fetch_en = 1'b1; bus.inst_ready = 1'b1;
    step(); step();
    rst = 1'b1;
    look();
    check_eq("t6_half_valid", 32'(bus.inst_valid), 0);
    step();
    rst = 1'b0;
    look();
    check_eq("t6_rst_valid", 32'(bus.inst_valid), 0);
    check_eq("t6_rst_raddr", 32'(bus.i_raddr), 0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step(); look();
      found = bus.inst_valid;
    end
    check_eq("t6_restart_found", 32'(found), 1);
    check_eq("t6_restart_pc", 32'(bus.inst_pc), 0);
    check_eq("t6_restart_inst", bus.inst, 32'h45678123);

    // Random traffic against the program-order model.
    do_reset();
    ovr.delete();
    r0 = retired;
    for (int c = 0; c < 3000; c++) begin
      step();
      fetch_en       = ($urandom_range(0, 99) < 85);
      bus.inst_ready = ($urandom_range(0, 99) < 70);
      bus.redirect   = ($urandom_range(0, 99) < 2);
      bus.redirect_pc = ($urandom_range(0, 1) == 1) ? PC_W'($urandom)
                                                     : (24'hFFFFF0 | PC_W'($urandom_range(0, 15)));
      rst = ($urandom_range(0, 999) < 3);
    end
    step();
    rst = 1'b0; bus.redirect = 1'b0;
    look();
    check_eq("rand_retired_enough", 32'(retired - r0 > 300), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
